// File: rtl/route_arbiter_stage.sv
// route_arbiter_stage
// Buffers flits on the x, y and local inputs, computes dimension-order (X then Y)
// routes for each FIFO head, arbitrates round-robin per output port and emits a
// registered one-cycle route code plus the transferred head flit per input.
// A per-input starvation flag rises after STARVE_LIMIT consecutive blocked cycles.
// Reset note: rst_n is asynchronous and ACTIVE-HIGH (rst_n=1 holds reset).
module route_arbiter_stage #(
    parameter int DATA_W       = 40,
    parameter int COORD_W      = 3,
    parameter int LOCAL_X      = 0,
    parameter int LOCAL_Y      = 0,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        in_valid,
    output logic [2:0]        in_ready,
    input  logic [DATA_W-1:0] din_x,
    input  logic [DATA_W-1:0] din_y,
    input  logic [DATA_W-1:0] din_local,
    input  logic [2:0]        out_ready,
    output logic [1:0]        route_out_x,
    output logic [1:0]        route_out_y,
    output logic [1:0]        route_out_local,
    output logic [DATA_W-1:0] dout_x,
    output logic [DATA_W-1:0] dout_y,
    output logic [DATA_W-1:0] dout_local,
    output logic [2:0]        fail
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BLK_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        CODE_NONE  = 2'b00,
        CODE_X     = 2'b01,
        CODE_Y     = 2'b10,
        CODE_LOCAL = 2'b11
    } route_code_e;

    // Input index order everywhere: 0 = x, 1 = y, 2 = local.
    logic [DATA_W-1:0] din_a  [3];
    logic [DATA_W-1:0] head   [3];
    route_code_e       req_code [3];

    logic [DATA_W-1:0] mem_q    [3][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d    [3][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [3];
    logic [PTR_W-1:0]  wr_ptr_d [3];
    logic [PTR_W-1:0]  rd_ptr_q [3];
    logic [PTR_W-1:0]  rd_ptr_d [3];
    logic [CNT_W-1:0]  count_q  [3];
    logic [CNT_W-1:0]  count_d  [3];
    logic [1:0]        rr_ptr_q [3];
    logic [1:0]        rr_ptr_d [3];
    logic [BLK_W-1:0]  blk_cnt_q [3];
    logic [BLK_W-1:0]  blk_cnt_d [3];
    logic [1:0]        route_q  [3];
    logic [1:0]        route_d  [3];
    logic [DATA_W-1:0] dout_q   [3];
    logic [DATA_W-1:0] dout_d   [3];
    logic [2:0]        fail_q;
    logic [2:0]        fail_d;

    logic [2:0] push;
    logic [2:0] gnt;
    logic [2:0] req_mask [3];
    logic [2:0] grant_oh [3];

    assign din_a[0] = din_x;
    assign din_a[1] = din_y;
    assign din_a[2] = din_local;

    // Round-robin pick: first requester at or after ptr, wrapping x,y,local.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] oh;
        int         idx;
        oh = '0;
        for (int k = 0; k < 3; k++) begin
            idx = (int'(ptr) + k) % 3;
            if (oh == 3'b000 && req[idx]) begin
                oh[idx] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Head flit of each FIFO and its dimension-order route request.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        for (int i = 0; i < 3; i++) begin
            head[i]     = mem_q[i][rd_ptr_q[i]];
            req_code[i] = CODE_NONE;
            if (count_q[i] != '0) begin
                if (head[i][DATA_W-1 -: COORD_W] != COORD_W'(LOCAL_X)) begin
                    req_code[i] = CODE_X;
                end else if (head[i][DATA_W-1-COORD_W -: COORD_W] != COORD_W'(LOCAL_Y)) begin
                    req_code[i] = CODE_Y;
                end else begin
                    req_code[i] = CODE_LOCAL;
                end
            end
        end
    end

    // Per-output round-robin arbitration and pointer advance.
    always_comb begin
        gnt = '0;
        for (int o = 0; o < 3; o++) begin
            rr_ptr_d[o] = rr_ptr_q[o];
            for (int i = 0; i < 3; i++) begin
                req_mask[o][i] = (req_code[i] == route_code_e'(o + 1)) && out_ready[o];
            end
            grant_oh[o] = rr_pick(req_mask[o], rr_ptr_q[o]);
            gnt         = gnt | grant_oh[o];
            case (grant_oh[o])
                3'b001:  rr_ptr_d[o] = 2'd1;
                3'b010:  rr_ptr_d[o] = 2'd2;
                3'b100:  rr_ptr_d[o] = 2'd0;
                default: rr_ptr_d[o] = rr_ptr_q[o];
            endcase
        end
    end

    // FIFO bookkeeping: ready from registered count only, pop on grant.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 3; i++) begin
            in_ready[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]     = in_valid[i] && in_ready[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = din_a[i];
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (gnt[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            case ({push[i], gnt[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    // Registered outputs and starvation counters.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            route_d[i]   = gnt[i] ? req_code[i] : CODE_NONE;
            dout_d[i]    = gnt[i] ? head[i] : dout_q[i];
            blk_cnt_d[i] = blk_cnt_q[i];
            if (count_q[i] == '0 || gnt[i]) begin
                blk_cnt_d[i] = '0;
            end else if (blk_cnt_q[i] != BLK_W'(STARVE_LIMIT)) begin
                blk_cnt_d[i] = blk_cnt_q[i] + BLK_W'(1);
            end
            fail_d[i] = (blk_cnt_q[i] == BLK_W'(STARVE_LIMIT));
        end
    end

    // FIFO storage; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; clearing count/pointers is enough to discard contents.
        mem_q <= mem_d;
    end

    // Control state with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                count_q[i]   <= '0;
                rr_ptr_q[i]  <= '0;
                blk_cnt_q[i] <= '0;
                route_q[i]   <= CODE_NONE;
                dout_q[i]    <= '0;
            end
            fail_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            blk_cnt_q <= blk_cnt_d;
            route_q   <= route_d;
            dout_q    <= dout_d;
            fail_q    <= fail_d;
        end
    end

    assign route_out_x     = route_q[0];
    assign route_out_y     = route_q[1];
    assign route_out_local = route_q[2];
    assign dout_x          = dout_q[0];
    assign dout_y          = dout_q[1];
    assign dout_local      = dout_q[2];
    assign fail            = fail_q;

endmodule

// File: tb/tb_route_arbiter_stage.sv
// Testbench for route_arbiter_stage: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_route_arbiter_stage;

    localparam int DATA_W       = 40;
    localparam int COORD_W      = 3;
    localparam int LOCAL_X      = 0;
    localparam int LOCAL_Y      = 0;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 8;

    typedef logic [DATA_W-1:0] flit_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    flit_t       din_x, din_y, din_local;
    logic [2:0]  out_ready;
    logic [1:0]  route_out_x, route_out_y, route_out_local;
    flit_t       dout_x, dout_y, dout_local;
    logic [2:0]  fail;

    route_arbiter_stage #(
        .DATA_W(DATA_W), .COORD_W(COORD_W), .LOCAL_X(LOCAL_X), .LOCAL_Y(LOCAL_Y),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_x(din_x), .din_y(din_y), .din_local(din_local),
        .out_ready(out_ready),
        .route_out_x(route_out_x), .route_out_y(route_out_y), .route_out_local(route_out_local),
        .dout_x(dout_x), .dout_y(dout_y), .dout_local(dout_local),
        .fail(fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue per input, plain round-robin pointers and
    // blocked-cycle counts, plus the output values expected after the next edge.
    flit_t       mdl_q [3][$];
    int          mdl_ptr [3];
    int          mdl_blk [3];
    logic [1:0]  exp_route [3];
    flit_t       exp_dout [3];
    logic [2:0]  exp_fail;

    function automatic flit_t make_flit(input int dx, input int dy, input logic [33:0] payload);
        flit_t f;
        f = {COORD_W'(dx), COORD_W'(dy), payload};
        return f;
    endfunction

    // Output port index (0=x,1=y,2=local) wanted by a flit under X-then-Y routing.
    function automatic int route_of(input flit_t f);
        int dx, dy;
        dx = int'(f[DATA_W-1 -: COORD_W]);
        dy = int'(f[DATA_W-1-COORD_W -: COORD_W]);
        if (dx != LOCAL_X) return 0;
        if (dy != LOCAL_Y) return 1;
        return 2;
    endfunction

    function automatic flit_t rand_flit();
        int dx, dy;
        dx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : LOCAL_X;
        dy = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : LOCAL_Y;
        return make_flit(dx, dy, {$urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mdl_q[i].delete();
            mdl_ptr[i]   = 0;
            mdl_blk[i]   = 0;
            exp_route[i] = 2'b00;
            exp_dout[i]  = '0;
        end
        exp_fail = 3'b000;
    endtask

    task automatic check_outputs();
        logic [2:0] exp_ready;
        for (int i = 0; i < 3; i++) exp_ready[i] = (mdl_q[i].size() < FIFO_DEPTH);
        check("in_ready",        64'(in_ready),        64'(exp_ready));
        check("route_out_x",     64'(route_out_x),     64'(exp_route[0]));
        check("route_out_y",     64'(route_out_y),     64'(exp_route[1]));
        check("route_out_local", 64'(route_out_local), 64'(exp_route[2]));
        check("dout_x",          64'(dout_x),          64'(exp_dout[0]));
        check("dout_y",          64'(dout_y),          64'(exp_dout[1]));
        check("dout_local",      64'(dout_local),      64'(exp_dout[2]));
        check("fail",            64'(fail),            64'(exp_fail));
    endtask

    // One clock cycle: check what the previous edge produced, drive new inputs,
    // then advance the model to what the coming edge must produce.
    task automatic step(input logic [2:0] v, input flit_t d0, input flit_t d1, input flit_t d2,
                        input logic [2:0] ordy);
        flit_t      d [3];
        logic [2:0] g;
        int         gout [3];
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        din_x     = d0;
        din_y     = d1;
        din_local = d2;
        out_ready = ordy;
        d[0] = d0; d[1] = d1; d[2] = d2;
        g = 3'b000;
        for (int i = 0; i < 3; i++) gout[i] = 0;
        for (int o = 0; o < 3; o++) begin
            if (ordy[o]) begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (mdl_ptr[o] + k) % 3;
                    if (!g[i] && mdl_q[i].size() > 0 && route_of(mdl_q[i][0]) == o) begin
                        g[i]       = 1'b1;
                        gout[i]    = o;
                        mdl_ptr[o] = (i + 1) % 3;
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            bit can_push;
            exp_fail[i] = (mdl_blk[i] == STARVE_LIMIT);
            if (mdl_q[i].size() == 0 || g[i]) mdl_blk[i] = 0;
            else if (mdl_blk[i] < STARVE_LIMIT) mdl_blk[i]++;
            exp_route[i] = g[i] ? 2'(gout[i] + 1) : 2'b00;
            can_push = (mdl_q[i].size() < FIFO_DEPTH);
            if (g[i]) exp_dout[i] = mdl_q[i].pop_front();
            if (v[i] && can_push) mdl_q[i].push_back(d[i]);
        end
    endtask

    task automatic idle(input int n, input logic [2:0] ordy);
        for (int c = 0; c < n; c++) step(3'b000, '0, '0, '0, ordy);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 3'b000;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b0;
    endtask

    initial begin
        flit_t fa, fb;
        rst_n     = 1'b1;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        din_x     = '0;
        din_y     = '0;
        din_local = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b0;

        // Single x-bound flit on the x input: code 01 one cycle after accept, then 00.
        step(3'b001, make_flit(2, 0, 34'h1_2345_6789), '0, '0, 3'b111);
        idle(3, 3'b111);

        // Three inputs all asking for the local output: granted x, y, local in turn.
        step(3'b111, make_flit(0, 0, 34'h111), make_flit(0, 0, 34'h222),
             make_flit(0, 0, 34'h333), 3'b000);
        idle(1, 3'b000);
        idle(5, 3'b100);

        // Local input fills with y-bound flits while y output is blocked -> starvation.
        for (int n = 0; n < 3; n++) step(3'b100, '0, '0, make_flit(0, 1, 34'(n + 16'h40)), 3'b101);
        idle(STARVE_LIMIT + 4, 3'b101);
        idle(5, 3'b111);

        // y input pushes a new flit in the same cycle its head is granted.
        fa = make_flit(0, 3, 34'h0_AAAA);
        fb = make_flit(0, 3, 34'h0_BBBB);
        step(3'b010, '0, fa, '0, 3'b111);
        step(3'b010, '0, fb, '0, 3'b111);
        idle(4, 3'b111);

        // Reset with flits buffered: nothing may emerge afterwards.
        step(3'b111, rand_flit(), rand_flit(), rand_flit(), 3'b000);
        step(3'b111, rand_flit(), rand_flit(), rand_flit(), 3'b000);
        apply_reset();
        idle(4, 3'b111);

        // Random traffic; some phases hold output ports mostly blocked to provoke starvation.
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] v, ordy;
            v = 3'($urandom());
            if ((c / 200) % 2 == 1) ordy = 3'($urandom()) & 3'($urandom()) & 3'($urandom());
            else ordy = 3'($urandom()) | 3'($urandom());
            step(v, rand_flit(), rand_flit(), rand_flit(), ordy);
            if (c == 1500) apply_reset();
        end
        idle(10, 3'b111);
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
